pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain.sv | 128 ++++++++++++
 tb/tb_pipe_chain.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain.sv
// Purpose: NSTAGE-deep valid/ready pipeline with per-stage hold and flush, elastic or lockstep.
// Latency: NSTAGE cycles from acceptance to out_valid when the chain runs unobstructed.
// Backpressure: elastic mode squeezes out bubbles; lockstep mode freezes every stage on any stall.
module pipe_chain #(
  parameter int NSTAGE   = 4,
  parameter int WIDTH    = 32,
  parameter int LOCKSTEP = 0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic [NSTAGE-1:0]          hold,
  input  logic [NSTAGE-1:0]          flush_mask,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [NSTAGE-1:0]          stage_valid,
  output logic [NSTAGE*WIDTH-1:0]    stage_data,
  output logic [$clog2(NSTAGE+1)-1:0] occupancy,
  output logic [15:0]                stall_cnt
);

  localparam int L  = NSTAGE - 1;
  localparam int OW = $clog2(NSTAGE + 1);

  logic [NSTAGE-1:0]            vld_q, vld_d;
  logic [NSTAGE-1:0][WIDTH-1:0] dat_q, dat_d;
  logic [OW-1:0]                occ_q, occ_d;
  logic [15:0]                  stall_q, stall_d;
  // Low during reset and for the first cycle after it, so nothing is
  // accepted before the first edge that follows deassertion.
  logic                         acc_en_q, acc_en_d;

  logic [NSTAGE-1:0] live, go, rdy, load;
  logic              frz;

  // Per-stage release (go) and readiness, from the last stage backwards.
  always_comb begin
    live = vld_q & ~flush_mask;
    go   = '0;
    rdy  = '0;
    frz  = 1'b0;
    if (LOCKSTEP != 0) begin
      // Any held live entry, or a blocked output, stops the whole chain.
      frz = (|(vld_q & hold & ~flush_mask)) | (live[L] & ~hold[L] & ~out_ready);
      go  = frz ? '0 : live;
      rdy = {NSTAGE{~frz}};
    end else begin
      go[L]  = live[L] & ~hold[L] & out_ready;
      rdy[L] = ~vld_q[L] | go[L] | flush_mask[L];
      for (int k = L - 1; k >= 0; k--) begin
        go[k]  = live[k] & ~hold[k] & rdy[k+1];
        rdy[k] = ~vld_q[k] | go[k] | flush_mask[k];
      end
    end
  end

  // Next stage contents: flush beats load, payload only moves on a load.
  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    load     = '0;
    occ_d    = '0;
    stall_d  = stall_q;
    acc_en_d = 1'b1;

    load[0] = in_valid & in_ready;
    for (int k = 1; k < NSTAGE; k++) begin
      load[k] = go[k-1];
    end

    if (flush_mask[0]) begin
      vld_d[0] = 1'b0;
    end else if (load[0]) begin
      vld_d[0] = 1'b1;
      dat_d[0] = in_data;
    end else if (go[0]) begin
      vld_d[0] = 1'b0;
    end

    for (int k = 1; k < NSTAGE; k++) begin
      if (flush_mask[k]) begin
        vld_d[k] = 1'b0;
      end else if (load[k]) begin
        vld_d[k] = 1'b1;
        dat_d[k] = dat_q[k-1];
      end else if (go[k]) begin
        vld_d[k] = 1'b0;
      end
    end

    for (int k = 0; k < NSTAGE; k++) begin
      occ_d = occ_d + OW'(vld_d[k]);
    end

    if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State registers; reset drops every in-flight entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q    <= '0;
      dat_q    <= '0;
      occ_q    <= '0;
      stall_q  <= '0;
      acc_en_q <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      dat_q    <= dat_d;
      occ_q    <= occ_d;
      stall_q  <= stall_d;
      acc_en_q <= acc_en_d;
    end
  end

  assign in_ready    = rdy[0] & acc_en_q;
  assign out_valid   = live[L] & ~hold[L];
  assign out_data    = dat_q[L];
  assign stage_valid = vld_q;
  assign stage_data  = dat_q;
  assign occupancy   = occ_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Bench for pipe_chain: one elastic and one lockstep instance (NSTAGE=4, WIDTH=32).
// Directed scenarios use hand-derived constants; random traffic uses a FIFO scoreboard.
// Inputs change at posedge+1, handshakes sampled at negedge, state checked at posedge+1.
module tb_pipe_chain;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic         e_in_valid, e_in_ready, e_out_valid, e_out_ready;
  logic [W-1:0] e_in_data, e_out_data;
  logic [N-1:0] e_hold, e_flush, e_sv;
  logic [N*W-1:0] e_sd;
  logic [2:0]   e_occ;
  logic [15:0]  e_stall;

  logic         k_in_valid, k_in_ready, k_out_valid, k_out_ready;
  logic [W-1:0] k_in_data, k_out_data;
  logic [N-1:0] k_hold, k_flush, k_sv;
  logic [N*W-1:0] k_sd;
  logic [2:0]   k_occ;
  logic [15:0]  k_stall;

  pipe_chain #(.NSTAGE(N), .WIDTH(W), .LOCKSTEP(0)) u_el (
    .clk(clk), .resetn(resetn), .in_valid(e_in_valid), .in_data(e_in_data), .in_ready(e_in_ready),
    .hold(e_hold), .flush_mask(e_flush), .out_valid(e_out_valid), .out_data(e_out_data),
    .out_ready(e_out_ready), .stage_valid(e_sv), .stage_data(e_sd), .occupancy(e_occ), .stall_cnt(e_stall));

  pipe_chain #(.NSTAGE(N), .WIDTH(W), .LOCKSTEP(1)) u_ls (
    .clk(clk), .resetn(resetn), .in_valid(k_in_valid), .in_data(k_in_data), .in_ready(k_in_ready),
    .hold(k_hold), .flush_mask(k_flush), .out_valid(k_out_valid), .out_data(k_out_data),
    .out_ready(k_out_ready), .stage_valid(k_sv), .stage_data(k_sd), .occupancy(k_occ), .stall_cnt(k_stall));

  int total = 0;
  int bad = 0;

  // Handshake samples taken at the negedge before each active edge.
  bit           e_rdy_s, e_ov_s, e_acc, e_del;
  bit           k_rdy_s, k_ov_s, k_acc, k_del;
  logic [W-1:0] e_od_s, k_od_s;
  logic [15:0]  e_stall_m, k_stall_m;

  task automatic idle_inputs();
    e_in_valid = 1'b0; e_in_data = '0; e_hold = '0; e_flush = '0; e_out_ready = 1'b0;
    k_in_valid = 1'b0; k_in_data = '0; k_hold = '0; k_flush = '0; k_out_ready = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    e_rdy_s = e_in_ready; e_ov_s = e_out_valid; e_od_s = e_out_data;
    e_acc = e_in_valid && e_in_ready; e_del = e_out_valid && e_out_ready;
    k_rdy_s = k_in_ready; k_ov_s = k_out_valid; k_od_s = k_out_data;
    k_acc = k_in_valid && k_in_ready; k_del = k_out_valid && k_out_ready;
    if (resetn && e_in_valid && !e_in_ready && e_stall_m != 16'hFFFF) e_stall_m = e_stall_m + 16'd1;
    if (resetn && k_in_valid && !k_in_ready && k_stall_m != 16'hFFFF) k_stall_m = k_stall_m + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    e_stall_m = '0; k_stall_m = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    e_stall_m = '0; k_stall_m = '0;
    e_in_valid = 1'b1; e_in_data = $urandom; e_out_ready = 1'b1;
    k_in_valid = 1'b1; k_in_data = $urandom; k_out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (e_sv !== 4'h0) begin bad++; $display("FAIL rst_e_sv got=%h exp=0", e_sv); end
    total++; if (e_occ !== 3'd0) begin bad++; $display("FAIL rst_e_occ got=%0d exp=0", e_occ); end
    total++; if (e_stall !== 16'd0) begin bad++; $display("FAIL rst_e_stall got=%0d exp=0", e_stall); end
    total++; if (e_sd !== '0) begin bad++; $display("FAIL rst_e_sd got=%h exp=0", e_sd); end
    total++; if (e_out_valid !== 1'b0) begin bad++; $display("FAIL rst_e_out_valid got=%b exp=0", e_out_valid); end
    total++; if (e_in_ready !== 1'b0) begin bad++; $display("FAIL rst_e_in_ready got=%b exp=0", e_in_ready); end
    total++; if (k_sv !== 4'h0) begin bad++; $display("FAIL rst_k_sv got=%h exp=0", k_sv); end
    total++; if (k_occ !== 3'd0) begin bad++; $display("FAIL rst_k_occ got=%0d exp=0", k_occ); end
    total++; if (k_sd !== '0) begin bad++; $display("FAIL rst_k_sd got=%h exp=0", k_sd); end
    total++; if (k_out_valid !== 1'b0) begin bad++; $display("FAIL rst_k_out_valid got=%b exp=0", k_out_valid); end
    @(posedge clk); #1;
    total++; if (e_sv !== 4'h0) begin bad++; $display("FAIL rst_hold_e_sv got=%h exp=0", e_sv); end
    idle_inputs();
    resetn = 1'b1;
    tick();
    total++; if (e_in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_e_in_ready got=%b exp=1", e_in_ready); end
    total++; if (k_in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_k_in_ready got=%b exp=1", k_in_ready); end
  endtask

  task automatic test_stream();
    int first;
    int got;
    first = -1; got = 0;
    do_reset();
    e_out_ready = 1'b1;
    for (int t = 0; t < 24; t++) begin
      if (t < 8) begin e_in_valid = 1'b1; e_in_data = 32'h10 + 32'(t); end
      else e_in_valid = 1'b0;
      tick();
      if (t < 8) begin
        total++; if (!e_acc) begin bad++; $display("FAIL stream_in_ready t=%0d got=%b exp=1", t, e_rdy_s); end
      end
      if (e_del) begin
        if (first < 0) first = t;
        total++; if (e_od_s !== 32'h10 + 32'(got)) begin bad++; $display("FAIL stream_data got=%h exp=%h", e_od_s, 32'h10 + 32'(got)); end
        got++;
      end
    end
    total++; if (first !== 4) begin bad++; $display("FAIL stream_latency got=%0d exp=4", first); end
    total++; if (got !== 8) begin bad++; $display("FAIL stream_count got=%0d exp=8", got); end
  endtask

  task automatic test_backpressure();
    do_reset();
    e_out_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      e_in_valid = 1'b1; e_in_data = 32'hA0 + 32'(t);
      tick();
      total++; if (!e_acc) begin bad++; $display("FAIL bp_fill t=%0d got=%b exp=1", t, e_rdy_s); end
    end
    e_in_valid = 1'b1; e_in_data = 32'hA4;
    for (int t = 0; t < 3; t++) begin
      tick();
      total++; if (e_rdy_s !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%b exp=0", e_rdy_s); end
    end
    total++; if (e_occ !== 3'd4) begin bad++; $display("FAIL bp_occ got=%0d exp=4", e_occ); end
    total++; if (e_stall !== 16'd3) begin bad++; $display("FAIL bp_stall got=%0d exp=3", e_stall); end
    e_out_ready = 1'b1;
    tick();
    total++; if (!(e_del && e_od_s === 32'hA0)) begin bad++; $display("FAIL bp_release got=%b/%h exp=1/a0", e_del, e_od_s); end
    total++; if (e_rdy_s !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", e_rdy_s); end
    e_out_ready = 1'b0; e_in_valid = 1'b0;
    total++; if (e_sd[3*W +: W] !== 32'hA1) begin bad++; $display("FAIL bp_st3 got=%h exp=a1", e_sd[3*W +: W]); end
    total++; if (e_sd[0 +: W] !== 32'hA4) begin bad++; $display("FAIL bp_st0 got=%h exp=a4", e_sd[0 +: W]); end
    total++; if (e_occ !== 3'd4) begin bad++; $display("FAIL bp_occ2 got=%0d exp=4", e_occ); end
  endtask

  task automatic test_compress();
    logic [W-1:0] dl[$];
    do_reset();
    e_out_ready = 1'b1;
    for (int t = 0; t < 15; t++) begin
      e_in_valid = (t == 0) || (t == 2);
      e_in_data  = (t == 0) ? 32'h01 : 32'h02;
      e_hold     = (t >= 4 && t <= 6) ? 4'b1000 : 4'b0000;
      tick();
      if (e_del) dl.push_back(e_od_s);
      if (t >= 4 && t <= 6) begin
        total++; if (e_ov_s !== 1'b0) begin bad++; $display("FAIL cmp_out_valid_held t=%0d got=%b exp=0", t, e_ov_s); end
      end
      if (t == 6) begin
        total++; if (e_occ !== 3'd2) begin bad++; $display("FAIL cmp_occ got=%0d exp=2", e_occ); end
        total++; if (e_sv !== 4'b1100) begin bad++; $display("FAIL cmp_sv got=%b exp=1100", e_sv); end
        total++; if (e_sd[2*W +: W] !== 32'h02) begin bad++; $display("FAIL cmp_st2 got=%h exp=02", e_sd[2*W +: W]); end
      end
    end
    total++; if (dl.size() !== 2) begin bad++; $display("FAIL cmp_count got=%0d exp=2", dl.size()); end
    else begin
      total++; if (dl[0] !== 32'h01 || dl[1] !== 32'h02) begin bad++; $display("FAIL cmp_order got=%h,%h exp=01,02", dl[0], dl[1]); end
    end
  endtask

  task automatic test_lockstep();
    int dt[$];
    logic [W-1:0] dd[$];
    do_reset();
    k_out_ready = 1'b1;
    for (int t = 0; t < 15; t++) begin
      k_in_valid = (t == 0) || (t >= 2 && t <= 5);
      k_in_data  = (t == 0) ? 32'h21 : 32'h22;
      k_hold     = (t >= 2 && t <= 4) ? 4'b0010 : 4'b0000;
      tick();
      if (k_del) begin dt.push_back(t); dd.push_back(k_od_s); end
      if (t >= 2 && t <= 4) begin
        total++; if (k_rdy_s !== 1'b0) begin bad++; $display("FAIL ls_in_ready_frozen t=%0d got=%b exp=0", t, k_rdy_s); end
        total++; if (k_sv !== 4'b0010) begin bad++; $display("FAIL ls_frozen_sv t=%0d got=%b exp=0010", t, k_sv); end
      end
      if (t == 4) begin
        total++; if (k_sd[1*W +: W] !== 32'h21) begin bad++; $display("FAIL ls_st1 got=%h exp=21", k_sd[1*W +: W]); end
      end
      if (t == 5) begin
        total++; if (k_rdy_s !== 1'b1) begin bad++; $display("FAIL ls_resume_in_ready got=%b exp=1", k_rdy_s); end
      end
    end
    total++; if (k_stall !== 16'd3) begin bad++; $display("FAIL ls_stall got=%0d exp=3", k_stall); end
    total++; if (dt.size() !== 2) begin bad++; $display("FAIL ls_count got=%0d exp=2", dt.size()); end
    else begin
      total++; if (dt[0] !== 7 || dd[0] !== 32'h21) begin bad++; $display("FAIL ls_first got=t%0d/%h exp=t7/21", dt[0], dd[0]); end
      total++; if (dt[1] !== 9 || dd[1] !== 32'h22) begin bad++; $display("FAIL ls_second got=t%0d/%h exp=t9/22", dt[1], dd[1]); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    e_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e_in_valid = 1'b1; e_in_data = 32'hB3 - 32'(i);
      tick();
    end
    total++; if (e_sv !== 4'hF || e_sd[0 +: W] !== 32'hB0 || e_sd[3*W +: W] !== 32'hB3) begin
      bad++; $display("FAIL fl_fill got=%b/%h/%h exp=1111/b0/b3", e_sv, e_sd[0 +: W], e_sd[3*W +: W]); end
    e_flush = 4'b0011; e_in_valid = 1'b1; e_in_data = 32'hBF; e_out_ready = 1'b1;
    tick();
    total++; if (!(e_del && e_od_s === 32'hB3)) begin bad++; $display("FAIL fl_out got=%b/%h exp=1/b3", e_del, e_od_s); end
    total++; if (e_sv !== 4'b1000) begin bad++; $display("FAIL fl_sv got=%b exp=1000", e_sv); end
    total++; if (e_sd[3*W +: W] !== 32'hB2) begin bad++; $display("FAIL fl_st3 got=%h exp=b2", e_sd[3*W +: W]); end
    total++; if (e_sd[0 +: W] !== 32'hB0) begin bad++; $display("FAIL fl_st0_payload got=%h exp=b0", e_sd[0 +: W]); end
    total++; if (e_occ !== 3'd1) begin bad++; $display("FAIL fl_occ got=%0d exp=1", e_occ); end
    e_flush = 4'b0000; e_in_valid = 1'b0;
    tick();
    total++; if (!(e_del && e_od_s === 32'hB2)) begin bad++; $display("FAIL fl_drain got=%b/%h exp=1/b2", e_del, e_od_s); end
    total++; if (e_occ !== 3'd0) begin bad++; $display("FAIL fl_empty got=%0d exp=0", e_occ); end
  endtask

  task automatic test_random();
    logic [W-1:0] eq[$];
    logic [W-1:0] kq[$];
    logic [N-1:0] h;
    do_reset();
    for (int t = 0; t < 600; t++) begin
      e_in_valid = ($urandom_range(0, 9) < 7); e_in_data = $urandom;
      e_out_ready = ($urandom_range(0, 9) < 7);
      h = '0;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 4) == 0) h[b] = 1'b1;
      e_hold = h;
      k_in_valid = ($urandom_range(0, 9) < 7); k_in_data = $urandom;
      k_out_ready = ($urandom_range(0, 9) < 7);
      // Inner-stage holds only while the consumer is not accepting.
      h = '0;
      if ($urandom_range(0, 4) == 0) h[3] = 1'b1;
      if (!k_out_ready) for (int b = 0; b < 3; b++) if ($urandom_range(0, 4) == 0) h[b] = 1'b1;
      k_hold = h;
      tick();
      if (e_acc) eq.push_back(e_in_data);
      if (e_del) begin
        total++;
        if (eq.size() == 0) begin bad++; $display("FAIL rnd_e_spurious got=%h exp=none", e_od_s); end
        else begin
          if (e_od_s !== eq[0]) begin bad++; $display("FAIL rnd_e_data got=%h exp=%h", e_od_s, eq[0]); end
          void'(eq.pop_front());
        end
      end
      if (k_acc) kq.push_back(k_in_data);
      if (k_del) begin
        total++;
        if (kq.size() == 0) begin bad++; $display("FAIL rnd_k_spurious got=%h exp=none", k_od_s); end
        else begin
          if (k_od_s !== kq[0]) begin bad++; $display("FAIL rnd_k_data got=%h exp=%h", k_od_s, kq[0]); end
          void'(kq.pop_front());
        end
      end
      total++; if (int'(e_occ) !== eq.size()) begin bad++; $display("FAIL rnd_e_occ got=%0d exp=%0d", e_occ, eq.size()); end
      total++; if ($countones(e_sv) !== eq.size()) begin bad++; $display("FAIL rnd_e_sv got=%b exp_pop=%0d", e_sv, eq.size()); end
      total++; if (int'(k_occ) !== kq.size()) begin bad++; $display("FAIL rnd_k_occ got=%0d exp=%0d", k_occ, kq.size()); end
    end
    total++; if (e_stall !== e_stall_m) begin bad++; $display("FAIL rnd_e_stall got=%0d exp=%0d", e_stall, e_stall_m); end
    total++; if (k_stall !== k_stall_m) begin bad++; $display("FAIL rnd_k_stall got=%0d exp=%0d", k_stall, k_stall_m); end
  endtask

  task automatic test_saturate_and_async_reset();
    do_reset();
    e_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e_in_valid = 1'b1; e_in_data = $urandom;
      tick();
    end
    e_in_valid = 1'b1;
    repeat (70000) tick();
    total++; if (e_stall !== 16'hFFFF) begin bad++; $display("FAIL sat_stall got=%h exp=ffff", e_stall); end
    e_out_ready = 1'b1; k_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e_in_valid = 1'b1; e_in_data = $urandom;
      k_in_valid = 1'b1; k_in_data = $urandom;
      tick();
    end
    #3;
    resetn = 1'b0;
    #1;
    total++; if (e_sv !== '0 || e_occ !== '0 || e_stall !== '0 || e_sd !== '0) begin
      bad++; $display("FAIL async_rst_e_state got=%b/%0d/%h exp=0/0/0", e_sv, e_occ, e_stall); end
    total++; if (e_out_valid !== 1'b0 || e_in_ready !== 1'b0) begin
      bad++; $display("FAIL async_rst_e_hs got=%b/%b exp=0/0", e_out_valid, e_in_ready); end
    total++; if (k_sv !== '0 || k_occ !== '0 || k_stall !== '0 || k_sd !== '0 || k_out_valid !== 1'b0) begin
      bad++; $display("FAIL async_rst_k got=%b/%0d/%h/%b exp=0/0/0/0", k_sv, k_occ, k_stall, k_out_valid); end
    e_stall_m = '0; k_stall_m = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    e_out_ready = 1'b0; e_in_valid = 1'b1; e_in_data = 32'h5A;
    tick();
    total++; if (e_occ > 3'd1) begin bad++; $display("FAIL post_rst_occ got=%0d exp<=1", e_occ); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    e_stall_m = '0; k_stall_m = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_compress();
    test_lockstep();
    test_flush();
    test_random();
    test_saturate_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
